// File: rtl/tdp18k_pkg.sv
// Shared types and constants for the TDP18K preload sequencer.
package tdp18k_pkg;

  localparam int DATA_W    = 18;
  localparam int ADDR_W    = 10;
  localparam int ID_W      = 20;
  localparam int ID_HALF_W = 10;
  localparam int PL_ADDR_W = 32;
  localparam int ID_HI_LSB = 22;
  localparam int ID_LO_LSB = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD,
    ST_DRAIN,
    ST_CMP
  } state_e;

  // Sequence parameters captured on START.
  typedef struct packed {
    logic              bcast;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] last_addr;
  } cfg_t;

  // Broadcast leaves both ID fields zero so every RAM decodes the row.
  function automatic logic [PL_ADDR_W-1:0] pl_addr(cfg_t cfg, logic [ADDR_W-1:0] row);
    logic [PL_ADDR_W-1:0] a;
    a = '0;
    a[ADDR_W-1:0] = row;
    if (!cfg.bcast) begin
      a[ID_HI_LSB +: ID_HALF_W] = cfg.id[ID_W-1:ID_HALF_W];
      a[ID_LO_LSB +: ID_HALF_W] = cfg.id[ID_HALF_W-1:0];
    end
    return a;
  endfunction

endpackage

// File: rtl/tdp18k_preload_ctl_if.sv
// Init-word stream plus the primitive's preload port, as seen by the sequencer.
interface tdp18k_preload_ctl_if;
  import tdp18k_pkg::*;

  logic [DATA_W-1:0]    S_DATA_i;
  logic                 S_VALID_i;
  logic                 S_READY_o;
  logic                 PL_INIT_o;
  logic                 PL_ENA_o;
  logic                 PL_WEN_o;
  logic                 PL_REN_o;
  logic [PL_ADDR_W-1:0] PL_ADDR_o;
  logic [DATA_W-1:0]    PL_DATA_o;
  logic [DATA_W-1:0]    PL_DATA_IN_i;

  modport slave (
    input  S_DATA_i, S_VALID_i, PL_DATA_IN_i,
    output S_READY_o, PL_INIT_o, PL_ENA_o, PL_WEN_o, PL_REN_o, PL_ADDR_o, PL_DATA_o
  );

  modport master (
    output S_DATA_i, S_VALID_i, PL_DATA_IN_i,
    input  S_READY_o, PL_INIT_o, PL_ENA_o, PL_WEN_o, PL_REN_o, PL_ADDR_o, PL_DATA_o
  );

endinterface

// File: rtl/tdp18k_preload_sum.sv
// Modulo-2^DATA_W accumulator with synchronous clear; sum_nxt_o is the value after this edge.
module tdp18k_preload_sum
  import tdp18k_pkg::*;
(
  input  logic              CLK_i,
  input  logic              RST_ni,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] add_i,
  output logic [DATA_W-1:0] sum_o,
  output logic [DATA_W-1:0] sum_nxt_o
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i)     sum_d = '0;
    else if (en_i) sum_d = sum_q + add_i;
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) sum_q <= '0;
    else         sum_q <= sum_d;
  end

  assign sum_o     = sum_q;
  assign sum_nxt_o = sum_d;

endmodule

// File: rtl/tdp18k_preload_ctl.sv
// TDP18K preload sequencer: streams init words into consecutive rows of one RAM or all RAMs.
// Define TDP18K_PRELOAD_VERIFY_EN to add readback of the rows and a checksum compare (ERR_o).
module tdp18k_preload_ctl
  import tdp18k_pkg::*;
(
  input  logic              CLK_i,
  input  logic              RST_ni,
  input  logic              START_i,
  input  logic              BCAST_i,
  input  logic [ID_W-1:0]   TARGET_ID_i,
  input  logic [ADDR_W-1:0] LAST_ADDR_i,
  output logic              BUSY_o,
  output logic              DONE_o,
  output logic              ERR_o,
  tdp18k_preload_ctl_if.slave pl
);

  state_e               state_q, state_d;
  cfg_t                 cfg_q, cfg_d;
  logic [ADDR_W-1:0]    row_q, row_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 wen_q, wen_d;
  logic [PL_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 accept, last_row, sum_clr;
  logic [DATA_W-1:0]    wsum, wsum_nxt_unused;

  assign accept   = (state_q == ST_WRITE) && pl.S_VALID_i;
  assign last_row = (row_q == cfg_q.last_addr);

`ifdef TDP18K_PRELOAD_VERIFY_EN
  logic              err_q, err_d;
  logic              ren_d;
  // [0] read issued this cycle (PL_REN_o), [1] readback word present on PL_DATA_IN_i
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  logic [DATA_W-1:0] rsum_nxt, rsum_unused;
`endif

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    row_d   = row_q;
    done_d  = 1'b0;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_clr = 1'b0;
`ifdef TDP18K_PRELOAD_VERIFY_EN
    err_d   = err_q;
    ren_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (START_i) begin
          cfg_d.bcast     = BCAST_i;
          cfg_d.id        = TARGET_ID_i;
          cfg_d.last_addr = LAST_ADDR_i;
          row_d           = '0;
          sum_clr         = 1'b1;
          state_d         = ST_WRITE;
`ifdef TDP18K_PRELOAD_VERIFY_EN
          err_d           = 1'b0;
`endif
        end
      end
      ST_WRITE: begin
        if (accept) begin
          wen_d  = 1'b1;
          addr_d = pl_addr(cfg_q, row_q);
          data_d = pl.S_DATA_i;
          if (last_row) begin
            row_d = '0;
`ifdef TDP18K_PRELOAD_VERIFY_EN
            if (cfg_q.bcast) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RD;
            end
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
`ifdef TDP18K_PRELOAD_VERIFY_EN
      ST_RD: begin
        ren_d  = 1'b1;
        addr_d = pl_addr(cfg_q, row_q);
        if (last_row) state_d = ST_DRAIN;
        else          row_d   = row_q + 1'b1;
      end
      ST_DRAIN: state_d = ST_CMP;
      ST_CMP: begin
        // The last readback word lands this cycle, so compare the post-edge sum.
        state_d = ST_IDLE;
        if (rsum_nxt == wsum) done_d = 1'b1;
        else                  err_d  = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Busy covers the cycle after leaving the last state so the final write/DONE sit under PL_ENA_o.
  assign busy_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      state_q <= ST_IDLE;
      cfg_q   <= '0;
      row_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      row_q   <= row_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  tdp18k_preload_sum u_wsum (
    .CLK_i     (CLK_i),
    .RST_ni    (RST_ni),
    .clr_i     (sum_clr),
    .en_i      (accept),
    .add_i     (pl.S_DATA_i),
    .sum_o     (wsum),
    .sum_nxt_o (wsum_nxt_unused)
  );

`ifdef TDP18K_PRELOAD_VERIFY_EN
  assign vld_pipe_d = {vld_pipe_q[0], ren_d};

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      err_q      <= err_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  tdp18k_preload_sum u_rsum (
    .CLK_i     (CLK_i),
    .RST_ni    (RST_ni),
    .clr_i     (sum_clr),
    .en_i      (vld_pipe_q[1]),
    .add_i     (pl.PL_DATA_IN_i),
    .sum_o     (rsum_unused),
    .sum_nxt_o (rsum_nxt)
  );

  assign pl.PL_REN_o = vld_pipe_q[0];
  assign ERR_o       = err_q;
`else
  logic unused_ok;
  assign unused_ok   = ^{pl.PL_DATA_IN_i, wsum};
  assign pl.PL_REN_o = 1'b0;
  assign ERR_o       = 1'b0;
`endif

  assign BUSY_o       = busy_q;
  assign DONE_o       = done_q;
  assign pl.S_READY_o = (state_q == ST_WRITE);
  assign pl.PL_ENA_o  = busy_q;
  assign pl.PL_INIT_o = busy_q & cfg_q.bcast;
  assign pl.PL_WEN_o  = wen_q;
  assign pl.PL_ADDR_o = addr_q;
  assign pl.PL_DATA_o = data_q;

endmodule

// File: tb/tb_tdp18k_preload_ctl.sv
// Bench for tdp18k_preload_ctl: table of directed and random preload runs checked against a
// row/checksum model plus a RAM/readback model; covers both TDP18K_PRELOAD_VERIFY_EN builds.
module tb_tdp18k_preload_ctl;
  import tdp18k_pkg::*;

`ifdef TDP18K_PRELOAD_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  typedef struct {
    bit          bcast;
    logic [19:0] id;
    int          last;
    int          pat;      // 0: k+1, 1: all ones, 2: hashed from seed
    int          gap;      // 0: none, 1: every other cycle, 2: random
    int          corrupt;  // row whose readback is flipped in bit 0, -1 none
    int unsigned seed;
    bit          exp_err;  // expected ERR when verify is built in
  } vec_t;

  logic              CLK_i = 1'b0;
  logic              RST_ni = 1'b0;
  logic              START_i = 1'b0;
  logic              BCAST_i = 1'b0;
  logic [19:0]       TARGET_ID_i = '0;
  logic [ADDR_W-1:0] LAST_ADDR_i = '0;
  logic              BUSY_o, DONE_o, ERR_o;

  tdp18k_preload_ctl_if pl();

  tdp18k_preload_ctl dut (
    .CLK_i       (CLK_i),
    .RST_ni      (RST_ni),
    .START_i     (START_i),
    .BCAST_i     (BCAST_i),
    .TARGET_ID_i (TARGET_ID_i),
    .LAST_ADDR_i (LAST_ADDR_i),
    .BUSY_o      (BUSY_o),
    .DONE_o      (DONE_o),
    .ERR_o       (ERR_o),
    .pl          (pl)
  );

  always #5 CLK_i = ~CLK_i;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM + readback path model: one row array, readback one cycle after the read strobe.
  logic [DATA_W-1:0] mem [0:1023];
  int corrupt_row = -1;

  always @(posedge CLK_i) begin
    if (pl.PL_ENA_o && pl.PL_WEN_o) mem[pl.PL_ADDR_o[9:0]] <= pl.PL_DATA_o;
    if (pl.PL_ENA_o && pl.PL_REN_o)
      pl.PL_DATA_IN_i <= mem[pl.PL_ADDR_o[9:0]] ^
                         ((int'(pl.PL_ADDR_o[9:0]) == corrupt_row) ? 18'h1 : 18'h0);
    else
      pl.PL_DATA_IN_i <= DATA_W'($urandom);
  end

  function automatic logic [DATA_W-1:0] word_of(input vec_t v, input int k);
    case (v.pat)
      0:       return DATA_W'(k + 1);
      1:       return 18'h3FFFF;
      default: return DATA_W'((v.seed * 32'h9E3779B1) ^ (32'(k) * 32'd40503));
    endcase
  endfunction

  function automatic logic [31:0] exp_addr(input vec_t v, input int row);
    logic [9:0] r;
    r = 10'(row);
    if (v.bcast) return {22'd0, r};
    return {v.id, 2'b00, r};
  endfunction

  // Checksum rule: 18-bit wrapping sums of written vs read-back words; broadcast never verifies.
  function automatic bit model_err(input vec_t v);
    logic [DATA_W-1:0] ws, rs, w;
    ws = '0;
    rs = '0;
    if (v.bcast) return 1'b0;
    for (int r = 0; r <= v.last; r++) begin
      w  = word_of(v, r);
      ws = ws + w;
      rs = rs + ((r == v.corrupt) ? (w ^ 18'h1) : w);
    end
    return ws != rs;
  endfunction

  function automatic vec_t mk(input bit b, input logic [19:0] id, input int last, input int pat,
                              input int gap, input int cor, input bit ee);
    vec_t v;
    v.bcast = b; v.id = id; v.last = last; v.pat = pat; v.gap = gap;
    v.corrupt = cor; v.seed = 32'd1; v.exp_err = ee;
    return v;
  endfunction

  task automatic run(input vec_t v);
    int  L, k, cyc, budget;
    int  last_wen, first_ren, last_ren, n_wen, n_ren, n_done, done_cyc, drop_cyc;
    bit  exp_wen, vld, stray_done, rd, e_err;
    logic [DATA_W-1:0] exp_data;
    int  exp_row;
    L = v.last; k = 0; cyc = 0; budget = 6 * (L + 1) + 40;
    last_wen = -1; first_ren = -1; last_ren = -1;
    n_wen = 0; n_ren = 0; n_done = 0; done_cyc = -1; drop_cyc = -1;
    exp_wen = 1'b0; stray_done = 1'b0; exp_data = '0; exp_row = 0;
    rd    = VERIFY && !v.bcast;
    e_err = VERIFY && !v.bcast && v.exp_err;
    corrupt_row = v.corrupt;

    @(negedge CLK_i);
    chk("idle_busy", 32'(BUSY_o), 32'd0);
    START_i = 1'b1; BCAST_i = v.bcast; TARGET_ID_i = v.id; LAST_ADDR_i = ADDR_W'(L);
    @(negedge CLK_i);
    START_i = 1'b0; BCAST_i = ~v.bcast; TARGET_ID_i = 20'($urandom); LAST_ADDR_i = ADDR_W'($urandom);
    chk("busy_rise", 32'(BUSY_o), 32'd1);
    chk("err_clr", 32'(ERR_o), 32'd0);
    cyc = 1;

    while (cyc < budget) begin
      if (pl.PL_WEN_o) begin n_wen++; last_wen = cyc; end
      chk("wen", 32'(pl.PL_WEN_o), 32'(exp_wen));
      if (exp_wen) begin
        chk("wr_addr", pl.PL_ADDR_o, exp_addr(v, exp_row));
        chk("wr_data", 32'(pl.PL_DATA_o), 32'(exp_data));
        chk("wr_init", 32'(pl.PL_INIT_o), 32'(v.bcast));
      end
      if (pl.PL_REN_o) begin
        if (first_ren < 0) first_ren = cyc;
        last_ren = cyc;
        chk("rd_addr", pl.PL_ADDR_o, exp_addr(v, n_ren));
        n_ren++;
      end
      if (DONE_o) begin n_done++; done_cyc = cyc; end
      if (!BUSY_o) begin drop_cyc = cyc; break; end
      chk("ena", 32'(pl.PL_ENA_o), 32'd1);

      START_i = 1'b0;
      exp_wen = 1'b0;
      if (k <= L) begin
        chk("ready", 32'(pl.S_READY_o), 32'd1);
        case (v.gap)
          0:       vld = 1'b1;
          1:       vld = (cyc % 2) == 1;
          default: vld = ($urandom_range(0, 3) != 0);
        endcase
        if (vld) begin
          pl.S_VALID_i = 1'b1;
          pl.S_DATA_i  = word_of(v, k);
          exp_wen = 1'b1; exp_data = word_of(v, k); exp_row = k;
          k++;
        end else begin
          pl.S_VALID_i = 1'b0;
          pl.S_DATA_i  = DATA_W'($urandom);
        end
        if (v.gap == 2 && k == 1 && !stray_done) begin
          START_i = 1'b1; stray_done = 1'b1;
        end
      end else begin
        chk("ready_lo", 32'(pl.S_READY_o), 32'd0);
        pl.S_VALID_i = 1'($urandom);
        pl.S_DATA_i  = DATA_W'($urandom);
      end
      @(negedge CLK_i);
      cyc++;
    end
    START_i = 1'b0;
    pl.S_VALID_i = 1'b0;

    chk("busy_drop", 32'(BUSY_o), 32'd0);
    chk("n_wen", 32'(n_wen), 32'(L + 1));
    chk("n_ren", 32'(n_ren), rd ? 32'(L + 1) : 32'd0);
    if (rd) begin
      chk("first_ren", 32'(first_ren), 32'(last_wen + 1));
      chk("ren_span", 32'(last_ren - first_ren), 32'(L));
    end
    chk("n_done", 32'(n_done), e_err ? 32'd0 : 32'd1);
    if (!e_err) chk("done_cyc", 32'(done_cyc), rd ? 32'(last_wen + L + 3) : 32'(last_wen));
    chk("busy_fall", 32'(drop_cyc), rd ? 32'(last_wen + L + 4) : 32'(last_wen + 1));
    chk("err", 32'(ERR_o), 32'(e_err));
    chk("init_idle", 32'(pl.PL_INIT_o), 32'd0);
    @(negedge CLK_i);
    chk("err_sticky", 32'(ERR_o), 32'(e_err));
  endtask

  task automatic reset_mid_write();
    vec_t v;
    v = mk(1'b0, 20'h12345, 7, 0, 0, -1, 1'b0);
    @(negedge CLK_i);
    START_i = 1'b1; BCAST_i = 1'b0; TARGET_ID_i = v.id; LAST_ADDR_i = 10'd7;
    @(negedge CLK_i);
    START_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pl.S_VALID_i = 1'b1;
      pl.S_DATA_i  = word_of(v, k);
      @(negedge CLK_i);
    end
    chk("rst_pre_wen", 32'(pl.PL_WEN_o), 32'd1);
    chk("rst_pre_addr", pl.PL_ADDR_o, exp_addr(v, 2));
    #1 RST_ni = 1'b0;
    #1;
    chk("rst_wen", 32'(pl.PL_WEN_o), 32'd0);
    chk("rst_ena", 32'(pl.PL_ENA_o), 32'd0);
    chk("rst_busy", 32'(BUSY_o), 32'd0);
    chk("rst_addr", pl.PL_ADDR_o, 32'd0);
    chk("rst_ready", 32'(pl.S_READY_o), 32'd0);
    chk("rst_done", 32'(DONE_o), 32'd0);
    chk("rst_err", 32'(ERR_o), 32'd0);
    pl.S_VALID_i = 1'b0;
    @(negedge CLK_i);
    RST_ni = 1'b1;
    @(negedge CLK_i);
    chk("rst_idle_busy", 32'(BUSY_o), 32'd0);
    chk("rst_idle_ready", 32'(pl.S_READY_o), 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    pl.S_VALID_i = 1'b0;
    pl.S_DATA_i  = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    vecs.push_back(mk(1'b0, 20'h00401, 3,    0, 0, -1, 1'b0));
    vecs.push_back(mk(1'b0, 20'h00401, 3,    0, 1, -1, 1'b0));
    vecs.push_back(mk(1'b0, 20'h00401, 3,    0, 0,  2, 1'b1));
    vecs.push_back(mk(1'b0, 20'h00401, 3,    0, 0, -1, 1'b0));
    vecs.push_back(mk(1'b1, 20'hABCDE, 0,    1, 0, -1, 1'b0));
    vecs.push_back(mk(1'b0, 20'hFFFFF, 1023, 1, 0, -1, 1'b0));
    vecs.push_back(mk(1'b0, 20'h80201, 0,    0, 0,  0, 1'b1));
    vecs.push_back(mk(1'b0, 20'h00401, 2,    0, 1, -1, 1'b0));
    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v.bcast   = ($urandom_range(0, 3) == 0);
      v.id      = 20'($urandom);
      v.last    = int'($urandom_range(0, 40));
      v.pat     = 2;
      v.gap     = int'($urandom_range(0, 2));
      v.seed    = $urandom;
      v.corrupt = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, v.last + 2));
      v.exp_err = model_err(v);
      vecs.push_back(v);
    end

    repeat (3) @(negedge CLK_i);
    chk("reset_busy", 32'(BUSY_o), 32'd0);
    chk("reset_done", 32'(DONE_o), 32'd0);
    chk("reset_err", 32'(ERR_o), 32'd0);
    chk("reset_ena", 32'(pl.PL_ENA_o), 32'd0);
    chk("reset_wen", 32'(pl.PL_WEN_o), 32'd0);
    chk("reset_ren", 32'(pl.PL_REN_o), 32'd0);
    chk("reset_init", 32'(pl.PL_INIT_o), 32'd0);
    chk("reset_addr", pl.PL_ADDR_o, 32'd0);
    chk("reset_data", 32'(pl.PL_DATA_o), 32'd0);
    chk("reset_ready", 32'(pl.S_READY_o), 32'd0);
    RST_ni = 1'b1;

    foreach (vecs[i]) run(vecs[i]);
    reset_mid_write();
    run(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run still active at %0t, limit 2000000", $time);
    $fatal(1);
  end

endmodule
